// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared core-width macros plus arbiter encodings for mem_arb.
// The macros live here (ahead of every user in compile order) so that the port
// widths and the FSM/owner codes share one definition across the core.
`ifndef MEM_ARB_DEFINES_SVH
`define MEM_ARB_DEFINES_SVH
`define CPU_WIDTH      64
`define LSU_OPT_WIDTH  4
`define ARB_ST_IDLE    2'd0
`define ARB_ST_ADDR    2'd1
`define ARB_ST_RESP    2'd2
`define ARB_OWN_IFU    1'b0
`define ARB_OWN_LSU    1'b1
`define ARB_STARVE_MAX 4
`endif

package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = `ARB_ST_IDLE,
    StAddr = `ARB_ST_ADDR,
    StResp = `ARB_ST_RESP
  } arb_state_e;

  typedef enum logic {
    OwnIfu = `ARB_OWN_IFU,
    OwnLsu = `ARB_OWN_LSU
  } arb_owner_e;

  localparam int unsigned CpuWidth = `CPU_WIDTH;

  // Streak value at which a contended request goes to the IFU instead of the LSU.
  localparam logic [1:0] StreakLast = 2'(`ARB_STARVE_MAX - 1);

  // Fetches always read a whole 8-byte memory word.
  function automatic logic [CpuWidth-1:0] align8(input logic [CpuWidth-1:0] addr);
    return {addr[CpuWidth-1:3], 3'b000};
  endfunction

endpackage

// File: rtl/mem_arb.sv
// mem_arb: shares a single memory port between instruction fetch (IFU) and
// load/store (LSU). One transaction in flight: IDLE (grant) -> ADDR (request
// held until i_mem_gnt) -> RESP (wait for i_mem_rvalid) -> IDLE.
// Ports:
//   i_clk, i_rst_n                        clock, async active-low reset
//   i_ifu_req/addr, o_ifu_gnt/rvalid/rdata  fetch client (32-bit word return)
//   i_lsu_req/addr/wen/wdata/wmask,
//   o_lsu_gnt/rvalid/rdata                load/store client
//   o_mem_req/addr/wen/wdata/wmask        memory request port
//   i_mem_gnt/rvalid/rdata                memory accept and response
module mem_arb
  import mem_arb_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_ifu_req,
  input  logic [`CPU_WIDTH-1:0] i_ifu_addr,
  output logic                  o_ifu_gnt,
  output logic                  o_ifu_rvalid,
  output logic [31:0]           o_ifu_rdata,
  input  logic                  i_lsu_req,
  input  logic [`CPU_WIDTH-1:0] i_lsu_addr,
  input  logic                  i_lsu_wen,
  input  logic [`CPU_WIDTH-1:0] i_lsu_wdata,
  input  logic [7:0]            i_lsu_wmask,
  output logic                  o_lsu_gnt,
  output logic                  o_lsu_rvalid,
  output logic [`CPU_WIDTH-1:0] o_lsu_rdata,
  output logic                  o_mem_req,
  output logic [`CPU_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_wen,
  output logic [`CPU_WIDTH-1:0] o_mem_wdata,
  output logic [7:0]            o_mem_wmask,
  input  logic                  i_mem_gnt,
  input  logic                  i_mem_rvalid,
  input  logic [`CPU_WIDTH-1:0] i_mem_rdata
);

  arb_state_e            state_q, state_d;
  arb_owner_e            owner_q;
  logic [1:0]            streak_q;
  logic [`CPU_WIDTH-1:0] addr_q;
  logic                  wen_q;
  logic [`CPU_WIDTH-1:0] wdata_q;
  logic [7:0]            wmask_q;

  logic pick_ifu;
  logic ifu_gnt, lsu_gnt;
  logic resp_fire;

  // LSU wins contention unless it has already won StreakLast times in a row.
  assign pick_ifu = i_ifu_req & (~i_lsu_req | (streak_q == StreakLast));

  // FSM: next state, grants and response strobes.
  always_comb begin
    state_d   = state_q;
    ifu_gnt   = 1'b0;
    lsu_gnt   = 1'b0;
    resp_fire = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Reset term keeps grants low while held in reset with requests high.
        ifu_gnt = i_rst_n & pick_ifu;
        lsu_gnt = i_rst_n & i_lsu_req & ~pick_ifu;
        if (i_ifu_req | i_lsu_req) state_d = StAddr;
      end
      StAddr: begin
        if (i_mem_gnt) state_d = StResp;
      end
      StResp: begin
        resp_fire = i_mem_rvalid;
        if (i_mem_rvalid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Saturating count of consecutive LSU grants taken while the IFU waited.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      streak_q <= '0;
    end else if (ifu_gnt) begin
      streak_q <= '0;
    end else if (lsu_gnt) begin
      if (!i_ifu_req)             streak_q <= '0;
      else if (streak_q != 2'd3)  streak_q <= streak_q + 2'd1;
    end
  end

  // Owner and payload captured at grant and held for the whole transaction.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      owner_q <= OwnLsu;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else if (ifu_gnt) begin
      owner_q <= OwnIfu;
      addr_q  <= i_ifu_addr;  // bit 2 kept for the word select on return
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else if (lsu_gnt) begin
      owner_q <= OwnLsu;
      addr_q  <= i_lsu_addr;
      wen_q   <= i_lsu_wen;
      wdata_q <= i_lsu_wdata;
      wmask_q <= i_lsu_wmask;
    end
  end

  assign o_ifu_gnt = ifu_gnt;
  assign o_lsu_gnt = lsu_gnt;

  assign o_mem_req   = (state_q == StAddr);
  assign o_mem_addr  = !o_mem_req          ? '0 :
                       (owner_q == OwnIfu) ? align8(addr_q) : addr_q;
  assign o_mem_wen   = o_mem_req & wen_q;
  assign o_mem_wdata = o_mem_req ? wdata_q : '0;
  assign o_mem_wmask = o_mem_req ? wmask_q : '0;

  assign o_ifu_rvalid = resp_fire & (owner_q == OwnIfu);
  assign o_lsu_rvalid = resp_fire & (owner_q == OwnLsu);
  assign o_ifu_rdata  = !o_ifu_rvalid ? '0 :
                        addr_q[2]     ? i_mem_rdata[CpuWidth-1:32] : i_mem_rdata[31:0];
  assign o_lsu_rdata  = o_lsu_rvalid ? i_mem_rdata : '0;

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset, named as elsewhere in the core: i_clk (in, 1) is the clock; i_rst_n (in, 1) is the reset.
REQ-002 i_ifu_req  in  1  instruction-fetch request, held until granted.
REQ-003 i_ifu_addr  in  `CPU_WIDTH  fetch byte address.
REQ-004 o_ifu_gnt  out  1  fetch request accepted this cycle.
REQ-005 o_ifu_rvalid  out  1  one-cycle pulse: fetch data valid.
REQ-006 o_ifu_rdata  out  32  instruction word.
REQ-007 i_lsu_req  in  1  load/store request, held until granted.
REQ-008 i_lsu_addr  in  `CPU_WIDTH  data address.
REQ-009 i_lsu_wen  in  1  1 = store, 0 = load.
REQ-010 i_lsu_wdata  in  `CPU_WIDTH  store data.
REQ-011 i_lsu_wmask  in  8  store byte strobes.
REQ-012 o_lsu_gnt  out  1  LSU request accepted this cycle.
REQ-013 o_lsu_rvalid  out  1  one-cycle pulse: load data valid or store acknowledged.
REQ-014 o_lsu_rdata  out  `CPU_WIDTH  load data.
REQ-015 o_mem_req, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_wmask  out  1/`CPU_WIDTH/1/`CPU_WIDTH/8  single memory-port request.
REQ-016 i_mem_gnt, i_mem_rvalid, i_mem_rdata  in  1/1/`CPU_WIDTH  memory accept, response pulse, and response data.

Function
REQ-017 SHALL implement the FSM IDLE -> ADDR -> RESP -> IDLE, with one transaction outstanding at most.
REQ-018 IDLE: if any request is present, SHALL select an owner, assert that owner's gnt combinationally in the same cycle, latch the owner and payload, and go to ADDR; with no request, SHALL stay in IDLE.
REQ-019 Arbitration SHALL give the LSU priority, except that when both request and lsu_streak == `ARB_STARVE_MAX-1 the IFU SHALL win.
REQ-020 lsu_streak (2 bits) SHALL increment on an LSU grant while i_ifu_req=1, and SHALL clear on any IFU grant or on an uncontended LSU grant; it SHALL never wrap.
REQ-021 ADDR: o_mem_req=1 SHALL drive the latched payload; the payload SHALL be stable until i_mem_gnt; on i_mem_gnt SHALL go to RESP.
REQ-022 An IFU-owned access SHALL drive o_mem_wen=0, o_mem_wmask=0, o_mem_wdata=0, with the address aligned down to 8 bytes.
REQ-023 RESP: on i_mem_rvalid SHALL pulse the owner's rvalid combinationally in the same cycle and return to IDLE; the non-owner's rvalid SHALL stay 0.
REQ-024 o_ifu_rdata SHALL be i_mem_rdata[63:32] when latched addr[2]=1, else [31:0]; o_lsu_rdata SHALL be i_mem_rdata unmodified.
REQ-025 i_mem_rvalid in IDLE or ADDR SHALL be ignored; i_mem_gnt outside ADDR SHALL be ignored.
REQ-026 The minimum transaction SHALL be 3 cycles (grant, address, response); back-to-back transactions SHALL have no idle bubble beyond the IDLE cycle.
REQ-027 Both gnt outputs SHALL never be 1 in the same cycle; gnt SHALL be 0 outside IDLE.

Reset
REQ-028 On i_rst_n=0 (asynchronous), SHALL force state=IDLE, lsu_streak=0, owner=LSU, and payload registers to 0.
REQ-029 All outputs SHALL be 0 during reset.
REQ-030 On reset mid-transaction, the transaction SHALL be abandoned silently; a late i_mem_rvalid after reset SHALL be ignored, per REQ-025.

Structure
REQ-031 The state encodings ARB_ST_IDLE/ADDR/RESP, the owner codes ARB_OWN_IFU/LSU, and ARB_STARVE_MAX=4 SHALL live in the shared define file used for the `CPU_WIDTH/`LSU_OPT_WIDTH macros.
REQ-032 SHALL be a single module with no sub-module; the FSM, streak counter, and payload register SHALL be kept in separate always blocks.

Verification
REQ-033 IFU-only: ifu_req, addr=0x80000004, mem gnt at once, rvalid 2 cycles later with rdata=0x1111_2222_3333_4444 -> o_ifu_rdata=0x11112222, one rvalid pulse, total 4 cycles.
REQ-034 Simultaneous ifu_req & lsu_req with lsu_streak=0 -> o_lsu_gnt first; IFU granted in the IDLE cycle after the LSU response.
REQ-035 LSU held busy while IFU requests continuously -> exactly 3 LSU grants, then 1 IFU grant; the pattern repeats.
REQ-036 Store: wen=1, wmask=0x0F, wdata=0xDEADBEEF, memory holds gnt low 5 cycles -> o_mem_* stable for all 5 cycles; o_lsu_rvalid pulses on rvalid.
REQ-037 Reset asserted in RESP, then rvalid arrives 1 cycle after release -> no rvalid output, state IDLE, next request served normally.
REQ-038 Spurious i_mem_rvalid in IDLE and in ADDR -> no rvalid output, no state change.
